// File: rtl/snake_pkg.sv
// Shared types and constants for the snake path storage blocks.
// Provides the default cell/pointer widths, the cell type and a depth helper.
package snake_pkg;

    localparam int CELL_W      = 8;
    localparam int PATH_ADDR_W = 8;

    typedef logic [CELL_W-1:0] cell_t;

    // Number of entries addressed by a pointer of the given width.
    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/sdp_ram_wf.sv
// Simple dual-port RAM with a registered, write-first read port.
// Ports: clk, we, d, write_address (write side); read_address, q (read side).
module sdp_ram_wf #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [DATA_W-1:0] d,
    input  logic [ADDR_W-1:0] write_address,
    input  logic [ADDR_W-1:0] read_address,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[write_address] <= d;
        end
        // A read of the word being written returns the new data.
        if (we && (write_address == read_address)) begin
            q <= d;
        end else begin
            q <= mem[read_address];
        end
    end

endmodule

// File: rtl/snake_path_fifo.sv
// Circular buffer holding the snake body as a queue of cell addresses.
// Ports: clk/reset; push/push_data, pop; rd_en/rd_index -> rd_data/rd_valid;
// status length, empty, full and sticky overflow/underflow.
module snake_path_fifo
    import snake_pkg::*;
#(
    parameter int DATA_W = CELL_W,
    parameter int ADDR_W = PATH_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_index,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   length,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = depth_of(ADDR_W);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] head_q, tail_q;
    logic [ADDR_W:0]   len_q, len_d;
    logic              empty_q, full_q;
    logic              ovf_q, unf_q;
    logic              valid_q, upd_q;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] ram_q;

    logic              push_ok, pop_ok, in_range, hit;
    logic [ADDR_W-1:0] rd_addr;

    assign push_ok  = push & (~full_q | pop);
    assign pop_ok   = pop & ~empty_q;
    assign rd_addr  = tail_q + rd_index;
    assign in_range = {1'b0, rd_index} < len_q;
    assign hit      = push_ok & (rd_addr == head_q);
    assign len_d    = len_q + {{ADDR_W{1'b0}}, push_ok}
                            - {{ADDR_W{1'b0}}, pop_ok};

    sdp_ram_wf #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk          (clk),
        .we           (push_ok & ~reset),
        .d            (push_data),
        .write_address(head_q),
        .read_address (rd_addr),
        .q            (ram_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            len_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            valid_q <= 1'b0;
            upd_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            if (push_ok) head_q <= head_q + 1'b1;
            if (pop_ok)  tail_q <= tail_q + 1'b1;
            len_q   <= len_d;
            empty_q <= (len_d == '0);
            full_q  <= (len_d == DEPTH_L);
            if (push & ~push_ok) ovf_q <= 1'b1;
            if (pop & ~pop_ok)   unf_q <= 1'b1;
            valid_q <= rd_en & in_range;
            // RAM output is taken for valid reads and for bypass hits;
            // otherwise the previous result is held.
            upd_q   <= rd_en & (in_range | hit);
            hold_q  <= rd_data;
        end
    end

    assign rd_data   = upd_q ? ram_q : hold_q;
    assign rd_valid  = valid_q;
    assign length    = len_q;
    assign empty     = empty_q;
    assign full      = full_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_snake_path_fifo.sv
// Self-checking bench for snake_path_fifo (DATA_W=8, ADDR_W=3).
// Table vectors plus a queue model with a read scoreboard.
module tb_snake_path_fifo;

    localparam int AW = 3;
    localparam int D  = 8;

    logic         clk = 1'b0;
    logic         reset, push, pop, rd_en;
    logic [7:0]   push_data;
    logic [AW-1:0] rd_index;
    logic [7:0]   rd_data;
    logic         rd_valid;
    logic [AW:0]  length;
    logic         empty, full, overflow, underflow;

    snake_path_fifo #(.DATA_W(8), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .push(push), .push_data(push_data),
        .pop(pop), .rd_en(rd_en), .rd_index(rd_index),
        .rd_data(rd_data), .rd_valid(rd_valid), .length(length),
        .empty(empty), .full(full), .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] d;
    } rd_exp_t;

    rd_exp_t    sb[$];
    logic [7:0] qm[$];
    logic [7:0] prev_d;
    logic       m_ovf, m_unf;
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive, update model, push expected read, compare after edge.
    task automatic step(input logic r, input logic ps, input logic [7:0] pd,
                        input logic pp, input logic re,
                        input logic [AW-1:0] idx);
        int      len;
        logic    ful, emp, pok, qok, vld, byp;
        rd_exp_t e;
        @(negedge clk);
        reset = r; push = ps; push_data = pd; pop = pp;
        rd_en = re; rd_index = idx;
        len = qm.size();
        ful = (len == D);
        emp = (len == 0);
        pok = ps && (!ful || pp);
        qok = pp && !emp;
        vld = re && (int'(idx) < len);
        byp = re && pok && (int'(idx) == (len % D));
        if (r) begin
            qm.delete();
            m_ovf = 0; m_unf = 0;
            prev_d = 8'h00;
            e.v = 0; e.d = 8'h00;
        end else begin
            if (byp)      prev_d = pd;
            else if (vld) prev_d = qm[idx];
            e.v = vld; e.d = prev_d;
            if (ps && !pok) m_ovf = 1;
            if (pp && !qok) m_unf = 1;
            if (qok) void'(qm.pop_front());
            if (pok) qm.push_back(pd);
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("rd_valid", int'(rd_valid), int'(e.v));
            chk("rd_data", int'(rd_data), int'(e.d));
        end
        chk("length", int'(length), qm.size());
        chk("empty", int'(empty), int'(qm.size() == 0));
        chk("full", int'(full), int'(qm.size() == D));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("underflow", int'(underflow), int'(m_unf));
    endtask

    typedef struct {
        logic       r, ps, pp, re;
        logic [7:0] pd;
        logic [2:0] idx;
        int         len;
        logic       v;
        logic [7:0] d;
    } vec_t;

    vec_t tbl[9];

    initial begin
        reset = 1; push = 0; pop = 0; rd_en = 0;
        push_data = 0; rd_index = 0;
        prev_d = 0; m_ovf = 0; m_unf = 0;

        tbl[0] = '{1, 0, 0, 0, 8'h00, 3'd0, 0, 0, 8'h00};
        tbl[1] = '{0, 1, 0, 0, 8'h11, 3'd0, 1, 0, 8'h00};
        tbl[2] = '{0, 1, 0, 0, 8'h22, 3'd0, 2, 0, 8'h00};
        tbl[3] = '{0, 1, 0, 0, 8'h33, 3'd0, 3, 0, 8'h00};
        tbl[4] = '{0, 0, 0, 1, 8'h00, 3'd0, 3, 1, 8'h11};
        tbl[5] = '{0, 0, 0, 1, 8'h00, 3'd1, 3, 1, 8'h22};
        tbl[6] = '{0, 0, 0, 1, 8'h00, 3'd2, 3, 1, 8'h33};
        tbl[7] = '{0, 0, 0, 1, 8'h00, 3'd3, 3, 0, 8'h33};
        tbl[8] = '{0, 0, 1, 0, 8'h00, 3'd0, 2, 0, 8'h33};

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].r, tbl[i].ps, tbl[i].pd, tbl[i].pp,
                 tbl[i].re, tbl[i].idx);
            chk($sformatf("tbl%0d_len", i), int'(length), tbl[i].len);
            chk($sformatf("tbl%0d_vld", i), int'(rd_valid), int'(tbl[i].v));
            chk($sformatf("tbl%0d_dat", i), int'(rd_data), int'(tbl[i].d));
        end

        // Fill, overflow, push with pop while full.
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 8'h40 + 8'(i), 0, 0, 0);
        chk("fill_full", int'(full), 1);
        step(0, 1, 8'h99, 0, 0, 0);
        chk("ovf_len", int'(length), 8);
        chk("ovf_flag", int'(overflow), 1);
        step(0, 1, 8'h50, 1, 0, 0);
        chk("pp_full_len", int'(length), 8);
        step(0, 0, 0, 0, 1, 3'd7);
        chk("idx7", int'(rd_data), 8'h50);
        step(0, 0, 0, 0, 1, 3'd0);
        chk("idx0", int'(rd_data), 8'h41);

        // Pop on empty with simultaneous push.
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 8'hAA, 1, 0, 0);
        chk("pe_len", int'(length), 1);
        chk("pe_unf", int'(underflow), 1);
        step(0, 0, 0, 0, 1, 3'd0);
        chk("pe_rd", int'(rd_data), 8'hAA);

        // Bypass at index == length.
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 8'h10, 0, 0, 0);
        step(0, 1, 8'h20, 0, 0, 0);
        step(0, 1, 8'h77, 0, 1, 3'd2);
        chk("byp_data", int'(rd_data), 8'h77);
        chk("byp_vld", int'(rd_valid), 0);
        step(0, 0, 0, 0, 1, 3'd2);
        chk("byp_next", int'(rd_data), 8'h77);
        chk("byp_next_v", int'(rd_valid), 1);

        // Wrap-around with push+pop pairs.
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 8'hC0 + 8'(i), 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 8'(i * 7 + 3), 1, 0, 0);
        chk("wrap_len", int'(length), 4);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 1, 3'(i));
            chk($sformatf("wrap_rd%0d", i), int'(rd_data),
                (16 + i) * 7 + 3);
        end

        // Reset while full, overflowed and with a read pending.
        for (int i = 0; i < 4; i++) step(0, 1, 8'h60 + 8'(i), 0, 0, 0);
        step(0, 1, 8'hEE, 0, 0, 0);
        chk("pre_rst_ovf", int'(overflow), 1);
        step(1, 1, 8'h55, 0, 1, 3'd0);
        chk("rst_len", int'(length), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_vld", int'(rd_valid), 0);
        chk("rst_data", int'(rd_data), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/snake_path_fifo.md
Name: snake_path_fifo

Overview:
- Parametrised successor to the game's 8x256 path RAM: a circular buffer holding the snake body as a queue of cell addresses.
- The movement FSM pushes the new head cell and pops the tail cell.
- The renderer and collision checker read any body segment by index, relative to the tail.
- Storage is a simple dual-port array with registered, write-first read, plus pointer, count and flag logic.

Parameters:
- DATA_W, 8: width of one stored cell address.
- ADDR_W, 8: pointer width; DEPTH = 2**ADDR_W entries.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- push  in  1  append push_data at head.
- push_data  in  DATA_W  cell to append.
- pop  in  1  drop oldest entry (tail).
- rd_en  in  1  read request.
- rd_index  in  ADDR_W  offset from tail; 0 = oldest segment.
- rd_data  out  DATA_W  registered read result.
- rd_valid  out  1  rd_data is valid this cycle.
- length  out  ADDR_W+1  current entry count, 0..DEPTH.
- empty  out  1  length == 0.
- full  out  1  length == DEPTH.
- overflow  out  1  sticky: push rejected while full.
- underflow  out  1  sticky: pop rejected while empty.

Behaviour:
- Reset: synchronous and active-high; the polarity and synchronicity are fixed. Reset takes priority over every other input in the same cycle.
  - Reset values: head_ptr=0, tail_ptr=0, length=0, rd_data=0, rd_valid=0, overflow=0, underflow=0, empty=1, full=0.
  - Array contents are not cleared.
  - Reset mid-operation discards the queue. A read issued in the reset cycle yields rd_valid=0 on the next cycle.
- Acceptance, evaluated on pre-edge state:
  - push_ok = push & (!full | pop).
  - pop_ok = pop & !empty.
- Updates:
  - push_ok: mem[head_ptr] <= push_data; head_ptr <= head_ptr+1.
  - pop_ok: tail_ptr <= tail_ptr+1.
  - Pointers wrap modulo DEPTH by natural ADDR_W overflow.
  - length <= length + push_ok - pop_ok.
- Simultaneous push and pop:
  - When full: both accepted, length unchanged, no overflow.
  - When empty: push accepted, pop ignored, underflow set, length becomes 1.
- Rejected operations:
  - push while full without pop: ignored; overflow <= 1.
  - pop while empty: ignored; underflow <= 1.
  - Both flags stay set until reset.
- Read path, 1-cycle latency:
  - rd_addr = tail_ptr + rd_index, mod DEPTH, using pre-edge tail_ptr even if a pop happens in the same cycle.
  - Next cycle: rd_valid = rd_en & (rd_index < length), with pre-edge length.
  - rd_data = mem[rd_addr] when valid.
  - When rd_valid=0, rd_data holds its previous value.
- Write-first bypass: if push_ok and rd_en and rd_addr == head_ptr in the same cycle, rd_data next cycle = push_data. In that case rd_valid still follows the rule above, so it is 0 when rd_index == length.
- length, empty and full are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Package snake_pkg:
  - CELL_W = 8 and PATH_ADDR_W = 8 defaults.
  - typedef cell_t as logic [CELL_W-1:0].
  - Localparam DEPTH derivation helper.
- Sub-module sdp_ram_wf (parameters DATA_W, ADDR_W):
  - Ports: clk, we, d, write_address, read_address, q.
  - Registered write-first read.
  - Reused by later tile-map blocks.
- The FIFO wrapper owns pointers, count, flags and valid.

Test Plan (DATA_W=8, ADDR_W=3, DEPTH=8):
- Reset, then push 8'h11, 8'h22, 8'h33 on consecutive cycles -> length=3, empty=0; rd_index=0,1,2 return 11, 22, 33, one cycle after each request, with rd_valid=1.
- Push 8 entries 0x40..0x47 -> full=1. Then push 0x99 alone -> ignored, length=8, overflow=1. Then push 0x50 with pop -> length=8; rd_index=7 returns 0x50 and rd_index=0 returns 0x41.
- Pop on empty with push 0xAA in the same cycle -> length=1, underflow=1; rd_index=0 returns 0xAA.
- length=2 (tail entry 0x10 at index 0), rd_en with rd_index=2 and push 0x77 in the same cycle -> next cycle rd_data=0x77 via bypass but rd_valid=0. Next cycle rd_index=2 -> 0x77 with rd_valid=1.
- Wrap-around: 20 push+pop pairs after filling 4 entries -> length stays 4, no flags; rd_index=0..3 return the last 4 pushed values in order.
- Assert reset while full with overflow=1 and a read pending -> next cycle length=0, empty=1, overflow=0, rd_valid=0.
